// File: rtl/shared_reg_write_arbiter.sv
// Round-robin single-writer port onto one shared W-bit register; ack is combinational and q/q_vld/gid follow one cycle later.
// No request queueing: clr blocks all grants, and an ungranted requester must hold req until it sees ack.
module shared_reg_write_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 8,
  localparam int GW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           cnt_clr,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           q_vld,
  output logic [GW-1:0]  gid,
  output logic [CW-1:0]  conflicts
);

  logic [GW-1:0] ptr;
  logic [GW-1:0] gnt;
  logic          gnt_vld;
  logic          contention;

  // Scan offsets from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = GW'(idx);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (rst && !clr && gnt_vld) ack[gnt] = 1'b1;
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign contention = !clr && ((req & (req - N'(1))) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      q_vld     <= 1'b0;
      gid       <= '0;
      ptr       <= '0;
      conflicts <= '0;
    end else begin
      if (clr) begin
        q     <= '0;
        q_vld <= 1'b0;
      end else if (gnt_vld) begin
        q     <= wdata[gnt*W +: W];
        q_vld <= 1'b1;
        gid   <= gnt;
        ptr   <= (gnt == GW'(N - 1)) ? '0 : gnt + GW'(1);
      end

      if (cnt_clr) begin
        conflicts <= '0;
      end else if (contention && (conflicts != {CW{1'b1}})) begin
        conflicts <= conflicts + CW'(1);
      end
    end
  end

endmodule

// File: doc/shared_reg_write_arbiter.md
# shared_reg_write_arbiter

Round-robin arbiter that owns one shared W-bit register and serialises write requests from N independent requesters onto it, so that no two writers ever drive the same storage in one cycle. It sits between the requesting datapath blocks and the shared state they update. It replaces ad-hoc multi-writer registers with a single writer port. A synchronous clear acts as the highest-priority writer. The block also counts contention cycles for debug.

## Interface

- N, 4, number of requesters (2..16)
- W, 8, width of the shared register and of each write-data lane
- CW, 8, width of the contention counter
- GW, $clog2(N), width of the writer-id output (derived, not overridden)

- clk  in  1  rising-edge clock; the block uses no other clock
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the shared register; highest priority
- req  in  N  write request, bit i belongs to requester i
- wdata  in  N*W  write data; requester i at bits [i*W +: W]
- cnt_clr  in  1  synchronous clear of the contention counter
- ack  out  N  one-hot (or zero) grant; combinational; ack[i]=1 means requester i's write is taken this cycle
- q  out  W  shared register value
- q_vld  out  1  shared register has been written since reset/clr
- gid  out  GW  id of the requester that performed the most recent write
- conflicts  out  CW  saturating count of contention cycles

## Operation

- State: q, q_vld, gid, conflicts, and rotating priority pointer ptr (GW bits, range 0..N-1).
- Arbitration, every cycle, combinational:
  - clr=1: ack=0; no requester is granted.
  - clr=0 and req≠0: g = first i with req[i]=1, scanning from ptr upward and wrapping N-1→0; ack = one-hot(g).
  - req=0: ack=0.
- Register update at the rising edge:
  - clr=1: q←0, q_vld←0. gid and ptr are unchanged.
  - Grant g: q←wdata lane g, q_vld←1, gid←g, ptr←(g+1) mod N. Wrap from N-1 to 0 is explicit; N need not be a power of two.
  - No grant: all state holds.
- Handshake:
  - A requester holds req and its wdata stable until it sees ack[i]=1 in the same cycle.
  - The write completes at that edge. The requester may drop req or present a new request in the next cycle.
  - The arbiter has no memory of ungranted requests; a requester that drops req before ack loses its write.
- Contention counter:
  - A contention cycle is one with clr=0 and popcount(req)≥2.
  - cnt_clr=1: conflicts←0. This has priority over increment.
  - Else, on a contention cycle, conflicts←conflicts+1, saturating at 2^CW-1 (no wrap).
- Fairness: with all N requests held continuously, grants rotate 0,1,…,N-1,0,… Each requester is granted within N cycles of asserting req, provided clr stays low.

## Timing

- ack: zero latency, combinational from req, ptr, clr and rst.
- q, q_vld, gid: one-cycle latency; they update at the edge ending the ack cycle.
- conflicts: updates at the edge ending the contention cycle.
- While rst=0: q=0, q_vld=0, gid=0, conflicts=0, ptr=0, and ack is forced to 0 asynchronously.
- Reset deassertion: the first edge with rst=1 may accept a write.
- Reset asserted mid-sequence: pending requests are discarded. After release, arbitration restarts from requester 0.
- clr and req in the same cycle: clr wins, and no ack is given. The requester must keep req asserted to be granted after clr drops.
- clr and cnt_clr are independent: clr does not touch conflicts, and cnt_clr does not touch q.

## Test plan

- Reset: assert rst=0 with req=4'b1111 → ack=0, q=0, q_vld=0, gid=0, conflicts=0. Release rst, hold req=4'b1111 → ack sequence 0001,0010,0100,1000,0001. q follows lanes 0,1,2,3; gid=0,1,2,3; conflicts=4 after four cycles.
- Single requester: only req[2], wdata lane2=8'hA5 → ack=4'b0100 the same cycle. Next cycle q=8'hA5, q_vld=1, gid=2, and ptr now points at 3. Then req=4'b0101 → lane 0 is granted first (wrap past 3), then lane 2.
- Clear priority: clr=1 with req=4'b0001, lane0=8'h3C → ack=0, q=0, q_vld=0, gid keeps its old value. Drop clr with req held → ack=4'b0001, then q=8'h3C.
- Counter saturation: CW=2 with 5 cycles of req=4'b0011 → conflicts 1,2,3,3,3. Apply cnt_clr=1 alongside req=4'b0011 → conflicts=0, while grants continue.
- Async reset mid-burst: with req=4'b1110 and ptr=2, pull rst low between clock edges → ack drops immediately and q=0. After release, the first grant goes to requester 1 (scan from 0).
- Non-power-of-two wrap: N=3, req=3'b111 for 6 cycles → ack 001,010,100,001,010,100, and ptr never reaches 3.
